crc_seq_ctrl: RTL
=================

Name: crc_seq_ctrl

Overview:
Sequencer sitting between the TLP source and the LCRC engine (crc + lfsr pair) on the transmit side of the replay buffer path.
- Accepts one 96-bit TLP at a time and assigns it a 12-bit sequence number.
- Starts the engine and waits for its ready, with a timeout.
- Forwards the 128-bit framed result (TLP + LCRC) with its sequence number to the replay buffer write port.
- Tracks unacknowledged entries and throttles intake when the replay window is full.

Parameters:
TLP_W, 96, width of TLP header/payload word into the engine
OUT_W, 128, width of the framed engine output
SEQ_W, 12, sequence number width (modulo 4096)
MAX_OUT, 8, maximum unacknowledged TLPs in the replay buffer
OCC_W, 4, width of the occupancy output (must hold MAX_OUT)
TIMEOUT, 64, WAIT cycles allowed before declaring an engine timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
tlp_valid  in  1  source TLP valid
tlp_ready  out  1  controller can accept a TLP
tlp_data  in  TLP_W  TLP from source
eng_start  out  1  one-cycle start/seed pulse to the engine
eng_tlp  out  TLP_W  TLP presented to the engine, held stable LOAD through WAIT
eng_seq  out  SEQ_W  sequence number of the TLP in flight
eng_rdy  in  1  engine result valid
eng_crc_out  in  OUT_W  framed engine result
rb_valid  out  1  replay buffer write request
rb_ready  in  1  replay buffer accepts the write
rb_data  out  OUT_W  framed TLP to the replay buffer
rb_seq  out  SEQ_W  sequence number of rb_data
ack_valid  in  1  ACK received from the link
ack_seq  in  SEQ_W  highest acknowledged sequence number
outstanding  out  OCC_W  count of unacknowledged TLPs
timeout_err  out  1  one-cycle pulse on engine timeout
busy  out  1  high in every state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous) clears state to IDLE and all of the following to 0: next_seq, ack_ptr, timeout counter, every output. Reset mid-operation discards the TLP in flight without writing it.
- FSM transitions:
  - IDLE -> LOAD on tlp_valid & tlp_ready. tlp_data is registered into eng_tlp and next_seq into eng_seq.
  - LOAD: eng_start=1 for exactly one cycle, then -> WAIT. The timeout counter clears.
  - WAIT: eng_rdy is sampled every cycle.
    - On eng_rdy=1: capture eng_crc_out into rb_data and eng_seq into rb_seq, then -> OUT.
    - If the counter reaches TIMEOUT-1 with eng_rdy=0: timeout_err=1 for one cycle, -> IDLE, next_seq is not advanced.
    - eng_rdy asserted outside WAIT is ignored.
  - OUT: rb_valid=1. rb_data and rb_seq are held stable until rb_ready.
    - On rb_valid & rb_ready: next_seq <= next_seq+1 (wraps 4095->0), -> IDLE.
    - No timeout applies in OUT.
- tlp_ready = (state==IDLE) & (outstanding < MAX_OUT), combinational from registered state.
- Minimum latency: accept at cycle T, eng_start at T+1, earliest eng_rdy sample at T+2, rb_valid at T+3. The next accept is possible the cycle after the rb handshake.
- outstanding = (next_seq - ack_ptr) mod 2^SEQ_W, where ack_ptr is the oldest unacknowledged sequence number.
- ACK handling is active in every state:
  - If ack_valid and d = (ack_seq - ack_ptr) mod 2^SEQ_W < outstanding, then ack_ptr <= ack_seq+1.
  - Otherwise (stale, duplicate, or ahead of next_seq) the ACK is ignored.
- Simultaneous rb handshake and valid ACK in one cycle: both update. outstanding reflects both next cycle.
- Full window: while outstanding==MAX_OUT, tlp_ready=0. A valid ACK raises tlp_ready on the following cycle.
- Sequence wrap: the arithmetic is modulo 4096 throughout. A window straddling 4095->0 must behave identically to one that does not.

Test Plan:
- Single TLP: after reset release, tlp_data=96'h123456789abcdefffff12345, engine returns eng_rdy 3 cycles after eng_start with eng_crc_out={tlp,32'hdeadbeef} -> one-cycle eng_start, rb_valid with rb_seq=0 and that rb_data, outstanding=1 after the handshake.
- Backpressure: rb_ready held low for 10 cycles -> rb_valid, rb_data and rb_seq stable throughout; tlp_ready=0; next_seq advances only on the handshake.
- Window full: 8 TLPs sent, no ACKs -> outstanding=8, tlp_ready=0. ack_seq=3 -> outstanding=4, tlp_ready=1 the next cycle. Stale ack_seq=2 afterwards -> no change.
- Timeout: eng_rdy never asserted -> timeout_err pulses exactly TIMEOUT cycles after WAIT entry, state returns to IDLE, the next TLP reuses the same eng_seq.
- Wrap: force 4094 TLPs sent and acked, then send 4 -> rb_seq 4094, 4095, 0, 1. ack_seq=0 -> outstanding=1.
- Reset mid-WAIT: rst pulled low while waiting -> all outputs 0 immediately. After release, the first TLP gets seq 0 and outstanding=0.

Source files
------------

// File: rtl/crc_seq_ctrl.sv
// Transmit-side LCRC sequencer: numbers each TLP, drives the CRC engine with a timeout,
// forwards the framed result to the replay buffer and throttles intake on a full replay window.
module crc_seq_ctrl #(
  parameter int TLP_W   = 96,
  parameter int OUT_W   = 128,
  parameter int SEQ_W   = 12,
  parameter int MAX_OUT = 8,
  parameter int OCC_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlp_valid,
  output logic             tlp_ready,
  input  logic [TLP_W-1:0] tlp_data,
  output logic             eng_start,
  output logic [TLP_W-1:0] eng_tlp,
  output logic [SEQ_W-1:0] eng_seq,
  input  logic             eng_rdy,
  input  logic [OUT_W-1:0] eng_crc_out,
  output logic             rb_valid,
  input  logic             rb_ready,
  output logic [OUT_W-1:0] rb_data,
  output logic [SEQ_W-1:0] rb_seq,
  input  logic             ack_valid,
  input  logic [SEQ_W-1:0] ack_seq,
  output logic [OCC_W-1:0] outstanding,
  output logic             timeout_err,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_INC  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0] SEQ_INC  = {{(SEQ_W-1){1'b0}}, 1'b1};
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(MAX_OUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t           state_r;
  logic [SEQ_W-1:0] next_seq_r;
  logic [SEQ_W-1:0] ack_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             eng_start_r;
  logic [TLP_W-1:0] eng_tlp_r;
  logic [SEQ_W-1:0] eng_seq_r;
  logic             rb_valid_r;
  logic [OUT_W-1:0] rb_data_r;
  logic [SEQ_W-1:0] rb_seq_r;
  logic             timeout_err_r;
  logic             busy_r;

  logic             tlp_ready_s;
  logic             accept_s;
  logic             hs_s;
  logic [SEQ_W-1:0] ack_dist_s;
  logic             ack_hit_s;
  logic [SEQ_W-1:0] next_seq_nxt_s;
  logic [SEQ_W-1:0] ack_ptr_nxt_s;
  logic [OCC_W-1:0] occ_nxt_s;

  // Intake gating, handshake detection, ACK window test and next pointer values
  always_comb begin
    tlp_ready_s    = 1'b0;
    hs_s           = 1'b0;
    ack_hit_s      = 1'b0;
    next_seq_nxt_s = next_seq_r;
    ack_ptr_nxt_s  = ack_ptr_r;

    // rst gates the ready so that every output reads 0 while reset is held
    if (rst && (state_r == ST_IDLE) && (occ_r < OCC_MAX)) begin
      tlp_ready_s = 1'b1;
    end else begin
      tlp_ready_s = 1'b0;
    end
    accept_s = tlp_valid & tlp_ready_s;

    if ((state_r == ST_OUT) && rb_valid_r && rb_ready) begin
      hs_s           = 1'b1;
      next_seq_nxt_s = next_seq_r + SEQ_INC;
    end else begin
      hs_s           = 1'b0;
      next_seq_nxt_s = next_seq_r;
    end

    // An ACK counts only if it names an entry inside the current unacknowledged window
    ack_dist_s = ack_seq - ack_ptr_r;
    if (ack_valid && (ack_dist_s < {{(SEQ_W-OCC_W){1'b0}}, occ_r})) begin
      ack_hit_s     = 1'b1;
      ack_ptr_nxt_s = ack_seq + SEQ_INC;
    end else begin
      ack_hit_s     = 1'b0;
      ack_ptr_nxt_s = ack_ptr_r;
    end

    occ_nxt_s = next_seq_nxt_s[OCC_W-1:0] - ack_ptr_nxt_s[OCC_W-1:0];
  end

  // Sequence/ACK pointers and registered occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_seq_r <= {SEQ_W{1'b0}};
      ack_ptr_r  <= {SEQ_W{1'b0}};
      occ_r      <= {OCC_W{1'b0}};
    end else begin
      next_seq_r <= next_seq_nxt_s;
      ack_ptr_r  <= ack_ptr_nxt_s;
      occ_r      <= occ_nxt_s;
    end
  end

  // Main sequencing FSM with its registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= {CNT_W{1'b0}};
      eng_start_r   <= 1'b0;
      eng_tlp_r     <= {TLP_W{1'b0}};
      eng_seq_r     <= {SEQ_W{1'b0}};
      rb_valid_r    <= 1'b0;
      rb_data_r     <= {OUT_W{1'b0}};
      rb_seq_r      <= {SEQ_W{1'b0}};
      timeout_err_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      eng_start_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            eng_tlp_r   <= tlp_data;
            eng_seq_r   <= next_seq_r;
            eng_start_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          wait_cnt_r <= {CNT_W{1'b0}};
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_rdy) begin
            rb_data_r  <= eng_crc_out;
            rb_seq_r   <= eng_seq_r;
            rb_valid_r <= 1'b1;
            state_r    <= ST_OUT;
          end else if (wait_cnt_r == CNT_LAST) begin
            // Abandon the TLP; next_seq is untouched so the retry reuses the number
            timeout_err_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_INC;
          end
        end
        ST_OUT: begin
          if (hs_s) begin
            rb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          rb_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tlp_ready   = tlp_ready_s;
  assign eng_start   = eng_start_r;
  assign eng_tlp     = eng_tlp_r;
  assign eng_seq     = eng_seq_r;
  assign rb_valid    = rb_valid_r;
  assign rb_data     = rb_data_r;
  assign rb_seq      = rb_seq_r;
  assign outstanding = occ_r;
  assign timeout_err = timeout_err_r;
  assign busy        = busy_r;

endmodule
